// File: rtl/elevator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_pkg
//  Description : Shared types and default sizing for the elevator datapath
//                (car controller and the floor-request encoder bench).
//  Revision    : 1.0 - initial release
// ============================================================================
package elevator_pkg;

    localparam int DEFAULT_WIDTH         = 8;  // number of floors
    localparam int DEFAULT_DEPTH         = 3;  // floor-index width
    localparam int DEFAULT_TRAVEL_CYCLES = 4;  // cycles per floor step
    localparam int DEFAULT_DOOR_CYCLES   = 6;  // cycles the door stays open

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } car_state_t;

endpackage
`default_nettype wire

// File: rtl/elevator_tick_timer.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_tick_timer
//  Description : Free-running 0..MAX-1 tick counter with synchronous clear;
//                done flags the last count so the owner can act on that edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_tick_timer #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic done
);

    // A one-cycle period still needs a 1-bit counter to stay well formed.
    localparam int            CW   = (MAX > 1) ? $clog2(MAX) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise wrap to zero after the last tick.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == LAST);

endmodule
`default_nettype wire

// File: rtl/elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : elevator_car_ctrl
//  Description : Elevator car sequencer. Moves the car one floor per
//                TRAVEL_CYCLES toward the encoded request, picks up requests
//                lying ahead on the way, opens the door for DOOR_CYCLES and
//                pulses serve back to the request latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module elevator_car_ctrl
    import elevator_pkg::*;
#(
    parameter int WIDTH         = DEFAULT_WIDTH,
    parameter int DEPTH         = DEFAULT_DEPTH,
    parameter int TRAVEL_CYCLES = DEFAULT_TRAVEL_CYCLES,
    parameter int DOOR_CYCLES   = DEFAULT_DOOR_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DEPTH-1:0] req_floor,
    input  logic             req_valid,
    output logic [DEPTH-1:0] cur_floor,
    output logic             dir_up,
    output logic             dir_down,
    output logic             door_open,
    output logic             serve_pulse,
    output logic [DEPTH-1:0] serve_floor,
    output logic             busy
);

    localparam logic [DEPTH-1:0] TOP_FLOOR = DEPTH'(WIDTH - 1);

    car_state_t       state_q,       state_d;
    logic [DEPTH-1:0] cur_floor_q,   cur_floor_d;
    logic [DEPTH-1:0] target_q,      target_d;
    logic             dir_up_q,      dir_up_d;
    logic             dir_down_q,    dir_down_d;
    logic             door_open_q,   door_open_d;
    logic             serve_pulse_q, serve_pulse_d;
    logic [DEPTH-1:0] serve_floor_q, serve_floor_d;
    logic             busy_q,        busy_d;

    logic             travel_done;
    logic             door_done;
    logic [DEPTH-1:0] eff_target;
    logic [DEPTH-1:0] next_floor;
    logic             at_limit;

    // Timers sit at zero outside their state, so each visit starts at count 0.
    elevator_tick_timer #(.MAX(TRAVEL_CYCLES)) u_travel_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != MOVE),
        .enable (state_q == MOVE),
        .done   (travel_done)
    );

    elevator_tick_timer #(.MAX(DOOR_CYCLES)) u_door_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q != DOOR),
        .enable (state_q == DOOR),
        .done   (door_done)
    );

    // Next-state and next-output decode for the car sequencer.
    always_comb begin
        state_d       = state_q;
        cur_floor_d   = cur_floor_q;
        target_d      = target_q;
        dir_up_d      = dir_up_q;
        dir_down_d    = dir_down_q;
        door_open_d   = door_open_q;
        serve_pulse_d = 1'b0;
        serve_floor_d = serve_floor_q;
        eff_target    = target_q;
        next_floor    = cur_floor_q;
        at_limit      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    target_d = req_floor;
                    if (req_floor == cur_floor_q) begin
                        state_d       = DOOR;
                        door_open_d   = 1'b1;
                        serve_pulse_d = 1'b1;
                        serve_floor_d = cur_floor_q;
                    end else begin
                        state_d    = MOVE;
                        dir_up_d   = (req_floor > cur_floor_q);
                        dir_down_d = !(req_floor > cur_floor_q);
                    end
                end
            end

            MOVE: begin
                // Only requests strictly ahead and short of the target are picked up.
                if (req_valid && dir_up_q &&
                    (req_floor > cur_floor_q) && (req_floor < target_q)) begin
                    eff_target = req_floor;
                end else if (req_valid && dir_down_q &&
                             (req_floor < cur_floor_q) && (req_floor > target_q)) begin
                    eff_target = req_floor;
                end
                target_d = eff_target;

                if (travel_done) begin
                    if (dir_up_q) begin
                        at_limit   = (cur_floor_q == TOP_FLOOR);
                        next_floor = cur_floor_q + 1'b1;
                    end else begin
                        at_limit   = (cur_floor_q == '0);
                        next_floor = cur_floor_q - 1'b1;
                    end

                    if (at_limit) begin
                        // Never wrap past the shaft ends; serve where the car is.
                        state_d       = DOOR;
                        dir_up_d      = 1'b0;
                        dir_down_d    = 1'b0;
                        door_open_d   = 1'b1;
                        serve_pulse_d = 1'b1;
                        serve_floor_d = cur_floor_q;
                    end else begin
                        cur_floor_d = next_floor;
                        if (next_floor == eff_target) begin
                            state_d       = DOOR;
                            dir_up_d      = 1'b0;
                            dir_down_d    = 1'b0;
                            door_open_d   = 1'b1;
                            serve_pulse_d = 1'b1;
                            serve_floor_d = next_floor;
                        end
                    end
                end
            end

            DOOR: begin
                if (door_done) begin
                    state_d     = IDLE;
                    door_open_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                dir_up_d    = 1'b0;
                dir_down_d  = 1'b0;
                door_open_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset drops the car back to the ground floor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cur_floor_q   <= '0;
            target_q      <= '0;
            dir_up_q      <= 1'b0;
            dir_down_q    <= 1'b0;
            door_open_q   <= 1'b0;
            serve_pulse_q <= 1'b0;
            serve_floor_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_floor_q   <= cur_floor_d;
            target_q      <= target_d;
            dir_up_q      <= dir_up_d;
            dir_down_q    <= dir_down_d;
            door_open_q   <= door_open_d;
            serve_pulse_q <= serve_pulse_d;
            serve_floor_q <= serve_floor_d;
            busy_q        <= busy_d;
        end
    end

    assign cur_floor   = cur_floor_q;
    assign dir_up      = dir_up_q;
    assign dir_down    = dir_down_q;
    assign door_open   = door_open_q;
    assign serve_pulse = serve_pulse_q;
    assign serve_floor = serve_floor_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_elevator_car_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_elevator_car_ctrl
//  Description : Scenario bench for the elevator car controller. Each trip's
//                expected timeline is worked out from floor distances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_elevator_car_ctrl;
    import elevator_pkg::*;

    localparam int W  = DEFAULT_WIDTH;
    localparam int DP = DEFAULT_DEPTH;
    localparam int T  = DEFAULT_TRAVEL_CYCLES;
    localparam int D  = DEFAULT_DOOR_CYCLES;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DP-1:0] req_floor = '0;
    logic          req_valid = 1'b0;
    logic [DP-1:0] cur_floor;
    logic          dir_up;
    logic          dir_down;
    logic          door_open;
    logic          serve_pulse;
    logic [DP-1:0] serve_floor;
    logic          busy;

    int n_checks    = 0;
    int n_fail      = 0;
    int model_floor = 0;  // where the car should be when idle
    int model_served = 0; // last floor reported on serve_floor

    always #5 clk = ~clk;

    elevator_car_ctrl #(
        .WIDTH         (W),
        .DEPTH         (DP),
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (D)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_floor   (req_floor),
        .req_valid   (req_valid),
        .cur_floor   (cur_floor),
        .dir_up      (dir_up),
        .dir_down    (dir_down),
        .door_open   (door_open),
        .serve_pulse (serve_pulse),
        .serve_floor (serve_floor),
        .busy        (busy)
    );

    // Bundle layout: {serve_floor, cur_floor, dir_up, dir_down, door_open, serve_pulse, busy}
    function automatic logic [2*DP+4:0] pack_exp(input int sf, input int cf, input bit up,
                                                 input bit dn, input bit door, input bit sp,
                                                 input bit bz);
        logic [DP-1:0] s;
        logic [DP-1:0] c;
        s = DP'(sf);
        c = DP'(cf);
        return {s, c, up, dn, door, sp, bz};
    endfunction

    // One trip starting from an idle cycle: request b, optional pickup p from MOVE cycle k on.
    task automatic run_trip(input int b, input int pre, input bit pv, input int p,
                            input int k, input string tag);
        int a, dir, stop, m, cur_k;
        logic [2*DP+4:0] exp_v, obs_v;
        a    = model_floor;
        dir  = (b > a) ? 1 : -1;
        stop = b;
        if (pv && (b != a)) begin
            cur_k = a + dir * (k / T);
            if ((dir > 0 && p > cur_k && p < b) || (dir < 0 && p < cur_k && p > b))
                stop = p;
        end
        m = ((stop > a) ? (stop - a) : (a - stop)) * T;

        req_floor = DP'(b);
        req_valid = 1'b1;
        @(posedge clk); #1;

        for (int c = 0; c < m; c++) begin
            exp_v = pack_exp(model_served, a + dir * (c / T), dir > 0, dir < 0, 1'b0, 1'b0, 1'b1);
            obs_v = {serve_floor, cur_floor, dir_up, dir_down, door_open, serve_pulse, busy};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s move cycle %0d: got %b expected %b", tag, c, obs_v, exp_v);
            end
            req_floor = (pv && c >= k) ? DP'(p) : DP'(pre);
            req_valid = 1'b1;
            @(posedge clk); #1;
        end

        for (int d = 0; d < D; d++) begin
            exp_v = pack_exp(stop, stop, 1'b0, 1'b0, 1'b1, d == 0, 1'b1);
            obs_v = {serve_floor, cur_floor, dir_up, dir_down, door_open, serve_pulse, busy};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s door cycle %0d: got %b expected %b", tag, d, obs_v, exp_v);
            end
            // Noise while the door is open must not start anything.
            req_floor = DP'($urandom_range(0, W - 1));
            req_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end

        model_floor  = stop;
        model_served = stop;
        exp_v = pack_exp(model_served, stop, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        obs_v = {serve_floor, cur_floor, dir_up, dir_down, door_open, serve_pulse, busy};
        n_checks++;
        if (obs_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s idle after door: got %b expected %b", tag, obs_v, exp_v);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [2*DP+4:0] obs_v;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        obs_v = {serve_floor, cur_floor, dir_up, dir_down, door_open, serve_pulse, busy};
        n_checks++;
        if (obs_v !== '0) begin
            n_fail++;
            $display("FAIL reset_initial: got %b expected 0", obs_v);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        model_floor  = 0;
        model_served = 0;
        // Abort a run in the middle of a cycle: outputs must drop without a clock edge.
        run_trip(3, 3, 1'b0, 0, 0, "pre_reset_trip");
        req_floor = DP'(6);
        req_valid = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        obs_v = {serve_floor, cur_floor, dir_up, dir_down, door_open, serve_pulse, busy};
        n_checks++;
        if (obs_v !== '0) begin
            n_fail++;
            $display("FAIL reset_async_midrun: got %b expected 0", obs_v);
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        obs_v = {serve_floor, cur_floor, dir_up, dir_down, door_open, serve_pulse, busy};
        n_checks++;
        if (obs_v !== '0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected 0", obs_v);
        end
        model_floor  = 0;
        model_served = 0;
    endtask

    task automatic test_same_floor();
        run_trip(model_floor, model_floor, 1'b0, 0, 0, "same_floor");
    endtask

    task automatic test_up_run();
        run_trip(5, 5, 1'b0, 0, 0, "up_run_0_to_5");
    endtask

    task automatic test_pickup();
        // Return to ground first, then 0->6 with floor 0 (behind) shown before floor 3 appears.
        run_trip(0, 0, 1'b0, 0, 0, "return_ground");
        run_trip(6, 0, 1'b1, 3, T, "pickup_at_3");
        // A pickup request beyond the target is ignored.
        run_trip(1, 1, 1'b1, 0, 0, "down_ignore_beyond");
    endtask

    task automatic test_down_run();
        run_trip(7, 7, 1'b0, 0, 0, "climb_to_7");
        run_trip(2, 2, 1'b0, 0, 0, "down_run_7_to_2");
    endtask

    task automatic test_idle_hold();
        logic [2*DP+4:0] exp_v, obs_v;
        req_valid = 1'b0;
        exp_v = pack_exp(model_served, model_floor, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 50; i++) begin
            req_floor = DP'($urandom_range(0, W - 1));
            @(posedge clk); #1;
            obs_v = {serve_floor, cur_floor, dir_up, dir_down, door_open, serve_pulse, busy};
            n_checks++;
            if (obs_v !== exp_v) begin
                n_fail++;
                $display("FAIL idle_hold cycle %0d: got %b expected %b", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back_random();
        int b, p, k, span;
        bit pv;
        for (int i = 0; i < 40; i++) begin
            b    = $urandom_range(0, W - 1);
            p    = $urandom_range(0, W - 1);
            pv   = 1'($urandom_range(0, 1));
            span = ((b > model_floor) ? (b - model_floor) : (model_floor - b)) * T;
            k    = (span > 0) ? $urandom_range(0, span - 1) : 0;
            run_trip(b, b, pv, p, k, "random_trip");
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_same_floor();
        test_up_run();
        test_pickup();
        test_down_run();
        test_idle_hold();
        test_back_to_back_random();
        test_same_floor();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
